// File: rtl/sico_if_buffer_pkg.sv
// Shared helpers for the SiCo interface buffer: width arithmetic and occupancy op codes.
package sico_if_buffer_pkg;

  // Ceiling log2, usable in constant expressions; returns 0 for values <= 1.
  function automatic int sico_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Occupancy counter width: one extra bit so a full FIFO (count == DEPTH) is representable.
  function automatic int sico_count_width(input int depth);
    return sico_clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    OCC_KEEP = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2,
    OCC_CLR  = 2'd3
  } occ_op_e;

endpackage

// File: rtl/sico_if_buffer_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port.
module sico_if_buffer_mem #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sico_if_buffer.sv
// Elastic FIFO between the SiCo interface player and the DUT, with occupancy/peak/stall statistics.
module sico_if_buffer
  import sico_if_buffer_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNTW  = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [WIDTH-1:0]                   data_i,
  input  logic                               valid_i,
  output logic                               hold_o,
  output logic [WIDTH-1:0]                   data_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  input  logic                               flush_i,
  output logic [sico_count_width(DEPTH)-1:0] count_o,
  output logic [sico_count_width(DEPTH)-1:0] peak_o,
  output logic [CNTW-1:0]                    stall_o
);

  localparam int AW = sico_clog2(DEPTH);
  localparam int CW = sico_count_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sico_if_buffer: DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("sico_if_buffer: WIDTH must be in 1..1024");
  end

  // Handshake: a beat moves on a rising edge when its valid is high and the
  // receiving side is not blocking (push: valid_i && !hold_o, pop: valid_o && ready_i).
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, peak_q, count_nxt;
  logic [CNTW-1:0]  stall_q;
  logic [WIDTH-1:0] rdata;
  logic             full, push, pop;
  occ_op_e          occ_op;

  assign full    = (count_q == CW'(DEPTH));
  assign hold_o  = full;
  assign valid_o = (count_q != '0);
  assign push    = valid_i && !full && !flush_i;
  assign pop     = valid_o && ready_i && !flush_i;
  assign data_o  = valid_o ? rdata : '0;
  assign count_o = count_q;
  assign peak_o  = peak_q;
  assign stall_o = stall_q;

  always_comb begin
    occ_op    = OCC_KEEP;
    count_nxt = count_q;
    if (flush_i)           occ_op = OCC_CLR;
    else if (push && !pop) occ_op = OCC_INC;
    else if (pop && !push) occ_op = OCC_DEC;
    case (occ_op)
      OCC_INC: count_nxt = count_q + CW'(1);
      OCC_DEC: count_nxt = count_q - CW'(1);
      OCC_CLR: count_nxt = '0;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      count_q <= count_nxt;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (count_nxt > peak_q) peak_q <= count_nxt;
      // Stall statistic survives flush and saturates instead of wrapping.
      if (valid_i && hold_o && stall_q != '1) stall_q <= stall_q + CNTW'(1);
    end
  end

  sico_if_buffer_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk_i),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(data_i),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_sico_if_buffer.sv
// Directed bench for sico_if_buffer: a DEPTH=4 instance for the main scenarios and a
// DEPTH=2/CNTW=4 instance for pointer wrap and stall-counter saturation.
module tb_sico_if_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic [7:0]  data_i, data_o;
  logic        valid_i, hold_o, valid_o, ready_i, flush_i;
  logic [2:0]  count_o, peak_o;
  logic [31:0] stall_o;

  // DEPTH=2, CNTW=4 instance
  logic [7:0]  d2_i, d2_o;
  logic        v2_i, h2_o, v2_o, r2_i, f2_i;
  logic [1:0]  c2_o, p2_o;
  logic [3:0]  s2_o;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [7:0] exp_q[$];
  int         model_peak;
  logic       m_push, m_pop;

  sico_if_buffer #(.WIDTH(8), .DEPTH(4), .CNTW(32)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .hold_o(hold_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .flush_i(flush_i),
    .count_o(count_o), .peak_o(peak_o), .stall_o(stall_o)
  );

  sico_if_buffer #(.WIDTH(8), .DEPTH(2), .CNTW(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(d2_i), .valid_i(v2_i), .hold_o(h2_o),
    .data_o(d2_o), .valid_o(v2_o), .ready_i(r2_i), .flush_i(f2_i),
    .count_o(c2_o), .peak_o(p2_o), .stall_o(s2_o)
  );

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    data_i = '0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    d2_i = '0; v2_i = 1'b0; r2_i = 1'b0; f2_i = 1'b0;
    model_peak = 0;

    // Reset and idle
    step(); step();
    chk("rst_hold", hold_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_peak", peak_o, 0);
    chk("rst_stall", stall_o, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("idle_stall", stall_o, 0);
    chk("idle_count", count_o, 0);
    chk("idle_valid", valid_o, 0);

    // Pass-through with ready_i held high
    ready_i = 1'b1; valid_i = 1'b1;
    data_i = 8'h11; step();
    chk("pt_data0", data_o, 8'h11); chk("pt_count0", count_o, 1);
    data_i = 8'h22; step();
    chk("pt_data1", data_o, 8'h22); chk("pt_count1", count_o, 1);
    data_i = 8'h33; step();
    chk("pt_data2", data_o, 8'h33); chk("pt_count2", count_o, 1);
    valid_i = 1'b0; step();
    chk("pt_empty_valid", valid_o, 0);
    chk("pt_empty_data", data_o, 0);
    chk("pt_peak", peak_o, 1);

    // Fill and stall
    ready_i = 1'b0; valid_i = 1'b1;
    data_i = 8'hA0; step(); chk("fill_count1", count_o, 1);
    data_i = 8'hA1; step(); chk("fill_count2", count_o, 2);
    data_i = 8'hA2; step(); chk("fill_count3", count_o, 3); chk("fill_hold3", hold_o, 0);
    data_i = 8'hA3; step(); chk("fill_count4", count_o, 4); chk("fill_hold4", hold_o, 1);
    data_i = 8'hA4; step(); step();
    chk("fill_stall", stall_o, 2);
    chk("fill_count_held", count_o, 4);
    chk("fill_head_stable", data_o, 8'hA0);
    chk("fill_peak", peak_o, 4);

    // Full with simultaneous pop: no push that edge, hold drops afterwards
    ready_i = 1'b1; step();
    chk("fullpop_count", count_o, 3);
    chk("fullpop_hold", hold_o, 0);
    chk("fullpop_data", data_o, 8'hA1);
    chk("fullpop_stall", stall_o, 3);
    step();
    chk("fullpop_next_count", count_o, 3);
    chk("drain_a2", data_o, 8'hA2);
    data_i = 8'hA5; step();
    chk("drain_a3", data_o, 8'hA3); chk("drain_count3", count_o, 3);
    valid_i = 1'b0; step();
    chk("drain_a4", data_o, 8'hA4); chk("drain_count2", count_o, 2);
    step();
    chk("drain_a5", data_o, 8'hA5); chk("drain_count1", count_o, 1);
    step();
    chk("drain_empty", valid_o, 0);

    // Flush with a concurrent push attempt
    ready_i = 1'b0; valid_i = 1'b1;
    data_i = 8'hB1; step();
    data_i = 8'hB2; step();
    data_i = 8'hB3; step();
    chk("fl_pre_count", count_o, 3);
    chk("fl_pre_head", data_o, 8'hB1);
    flush_i = 1'b1; data_i = 8'h55; step();
    chk("fl_count", count_o, 0);
    chk("fl_valid", valid_o, 0);
    chk("fl_peak", peak_o, 4);
    chk("fl_stall", stall_o, 3);
    flush_i = 1'b0; valid_i = 1'b0; step();
    chk("fl_not_stored", count_o, 0);
    valid_i = 1'b1; data_i = 8'h66; step();
    chk("fl_after_data", data_o, 8'h66);
    chk("fl_after_count", count_o, 1);
    valid_i = 1'b0; ready_i = 1'b1; step();
    chk("fl_after_drain", valid_o, 0);

    // Wrap: random traffic on DEPTH=2 against a queue model
    for (int i = 0; i < 1000; i++) begin
      v2_i = 1'($urandom_range(0, 1));
      r2_i = 1'($urandom_range(0, 1));
      d2_i = 8'($urandom_range(0, 255));
      m_push = v2_i && (exp_q.size() != 2);
      m_pop  = r2_i && (exp_q.size() != 0);
      step();
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(d2_i);
      if (exp_q.size() > model_peak) model_peak = exp_q.size();
      chk("wrap_count", c2_o, exp_q.size());
      chk("wrap_hold", h2_o, exp_q.size() == 2);
      chk("wrap_data", d2_o, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
    end
    chk("wrap_peak", p2_o, model_peak);

    // Saturation of the 4-bit stall counter
    v2_i = 1'b0; r2_i = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("sat_rst_stall", s2_o, 0);
    v2_i = 1'b1; d2_i = 8'hC0; step(); d2_i = 8'hC1; step();
    chk("sat_full", h2_o, 1);
    for (int i = 0; i < 10; i++) step();
    chk("sat_stall10", s2_o, 10);
    for (int i = 0; i < 10; i++) step();
    chk("sat_stall20", s2_o, 15);
    chk("sat_head", d2_o, 8'hC0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
